// File: rtl/dsm_cfg_ctrl_if.sv
// rtl/dsm_cfg_ctrl_if.sv - request handshake, serial programming and readback signals of dsm_cfg_ctrl
interface dsm_cfg_ctrl_if;
    logic       req_valid;
    logic [8:0] req_word;
    logic       req_ready;
    logic       sclk;
    logic       sdata;
    logic       en;
    logic       busy;
    logic       done;
    logic [8:0] rb_word;
    logic       rb_err;

    modport master (
        output req_valid,
        output req_word,
        output rb_word,
        input  req_ready,
        input  sclk,
        input  sdata,
        input  en,
        input  busy,
        input  done,
        input  rb_err
    );

    modport slave (
        input  req_valid,
        input  req_word,
        input  rb_word,
        output req_ready,
        output sclk,
        output sdata,
        output en,
        output busy,
        output done,
        output rb_err
    );
endinterface

// File: rtl/dsm_cfg_ctrl.sv
// rtl/dsm_cfg_ctrl.sv - serial shift-register programmer for the DSM config word (optional readback check: DSM_CFG_READBACK_EN)
module dsm_cfg_ctrl #(
    parameter int CLK_DIV = 2
) (
    input  logic         clk_dsm,
    input  logic         rst_n,
    dsm_cfg_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SETUP    = 3'd1,
        S_SHIFT_HI = 3'd2,
        S_SHIFT_LO = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    // Every phase lasts CLK_DIV cycles: the divider counts CLK_DIV-1 down to 0.
    localparam logic [7:0] DIV_RELOAD = 8'(CLK_DIV - 1);

    state_t     state;
    logic [8:0] shadow;
    logic [3:0] bit_cnt;
    logic [7:0] div_cnt;

    logic       sclk_q;
    logic       sdata_q;
    logic       en_q;
    logic       busy_q;
    logic       done_q;
    logic       req_ready_q;

    logic       accept;
    logic       phase_end;
    logic [3:0] lo_idx;
    logic       lo_bit;

    assign accept    = bus.req_valid & req_ready_q;
    assign phase_end = (div_cnt == 8'd0);

    // Bit presented on entry to SHIFT_LO: the next lower bit, or 0 once bit 0 has been clocked (hold phase).
    assign lo_idx = bit_cnt - 4'd1;
    assign lo_bit = (bit_cnt == 4'd0) ? 1'b0 : shadow[lo_idx];

    // Main FSM; all pins are registered here so sclk/sdata/en come straight from flops.
    always_ff @(posedge clk_dsm or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            shadow      <= 9'd0;
            bit_cnt     <= 4'd0;
            div_cnt     <= 8'd0;
            sclk_q      <= 1'b0;
            sdata_q     <= 1'b0;
            en_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            req_ready_q <= 1'b1;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        state       <= S_SETUP;
                        shadow      <= bus.req_word;
                        bit_cnt     <= 4'd8;
                        div_cnt     <= DIV_RELOAD;
                        en_q        <= 1'b1;
                        sclk_q      <= 1'b0;
                        sdata_q     <= bus.req_word[8];
                        busy_q      <= 1'b1;
                        req_ready_q <= 1'b0;
                    end else begin
                        state       <= S_IDLE;
                        en_q        <= 1'b0;
                        sclk_q      <= 1'b0;
                        sdata_q     <= 1'b0;
                        busy_q      <= 1'b0;
                        req_ready_q <= 1'b1;
                    end
                end
                S_SETUP: begin
                    if (phase_end) begin
                        state   <= S_SHIFT_HI;
                        div_cnt <= DIV_RELOAD;
                        sclk_q  <= 1'b1;
                    end else begin
                        div_cnt <= div_cnt - 8'd1;
                    end
                end
                S_SHIFT_HI: begin
                    if (phase_end) begin
                        state   <= S_SHIFT_LO;
                        div_cnt <= DIV_RELOAD;
                        sclk_q  <= 1'b0;
                        sdata_q <= lo_bit;
                    end else begin
                        div_cnt <= div_cnt - 8'd1;
                    end
                end
                S_SHIFT_LO: begin
                    if (phase_end) begin
                        if (bit_cnt != 4'd0) begin
                            state   <= S_SHIFT_HI;
                            bit_cnt <= bit_cnt - 4'd1;
                            div_cnt <= DIV_RELOAD;
                            sclk_q  <= 1'b1;
                        end else begin
                            state       <= S_DONE;
                            en_q        <= 1'b0;
                            sclk_q      <= 1'b0;
                            sdata_q     <= 1'b0;
                            done_q      <= 1'b1;
                            req_ready_q <= 1'b1;
                        end
                    end else begin
                        div_cnt <= div_cnt - 8'd1;
                    end
                end
                default: begin
                    state       <= S_IDLE;
                    en_q        <= 1'b0;
                    sclk_q      <= 1'b0;
                    sdata_q     <= 1'b0;
                    busy_q      <= 1'b0;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.sclk      = sclk_q;
    assign bus.sdata     = sdata_q;
    assign bus.en        = en_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.req_ready = req_ready_q;

`ifdef DSM_CFG_READBACK_EN
    logic rb_err_q;

    // Sticky mismatch flag: set from the DONE-cycle compare, cleared by the next accepted word.
    always_ff @(posedge clk_dsm or negedge rst_n) begin
        if (!rst_n) begin
            rb_err_q <= 1'b0;
        end else if (state == S_DONE && bus.rb_word != shadow) begin
            rb_err_q <= 1'b1;
        end else if (accept) begin
            rb_err_q <= 1'b0;
        end
    end

    assign bus.rb_err = rb_err_q;
`else
    logic unused_rb;
    assign unused_rb  = ^bus.rb_word;
    assign bus.rb_err = 1'b0;
`endif

endmodule

// File: tb/tb_dsm_cfg_ctrl.sv
// tb/tb_dsm_cfg_ctrl.sv - randomized self-checking bench for dsm_cfg_ctrl (CLK_DIV=2 and CLK_DIV=1 instances)
module tb_dsm_cfg_ctrl;

    logic clk = 1'b0;
    logic rst_a = 1'b0;
    logic rst_b = 1'b0;
    always #5 clk = ~clk;

    dsm_cfg_ctrl_if if_a ();
    dsm_cfg_ctrl_if if_b ();

    dsm_cfg_ctrl #(.CLK_DIV(2)) u_a (.clk_dsm(clk), .rst_n(rst_a), .bus(if_a));
    dsm_cfg_ctrl #(.CLK_DIV(1)) u_b (.clk_dsm(clk), .rst_n(rst_b), .bus(if_b));

    // Downstream shift-register models: shift sdata in on each sclk rise while enabled.
    logic [8:0] sr_a = 9'd0;
    logic [8:0] sr_b = 9'd0;
    logic       rb_force_a = 1'b0;
    always @(posedge if_a.sclk) if (if_a.en) sr_a <= {sr_a[7:0], if_a.sdata};
    always @(posedge if_b.sclk) if (if_b.en) sr_b <= {sr_b[7:0], if_b.sdata};
    assign if_a.rb_word = rb_force_a ? 9'h000 : sr_a;
    assign if_b.rb_word = sr_b;

    int n_tests = 0;
    int n_fail  = 0;

    // Measurements of one CLK_DIV=2 transfer
    int         m_en_cnt, m_done_at, m_nrise;
    logic [8:0] m_bits, m_sr;
    logic [4:0] m_setup, m_done_out;
    logic [1:0] m_hold;
    logic       m_idle_busy, m_rb_after;

    localparam int D_A = 2;

    task automatic drive_a(input logic [8:0] w, input int pulse_at);
        int   g;
        logic prev;
        g = 0;
        @(negedge clk);
        while (!if_a.req_ready && g < 100) begin @(negedge clk); g++; end
        if_a.req_valid = 1'b1;
        if_a.req_word  = w;
        @(posedge clk);
        #1;
        if_a.req_valid = 1'b0;
        if_a.req_word  = 9'($urandom);
        prev = 1'b0;
        m_en_cnt = 0; m_done_at = 0; m_nrise = 0; m_bits = 9'd0; m_sr = 9'd0;
        m_setup = 5'd0; m_done_out = 5'd0; m_hold = 2'd0; m_idle_busy = 1'b1; m_rb_after = 1'b0;
        for (int c = 1; c <= 19 * D_A + 5; c++) begin
            @(negedge clk);
            if (if_a.en) m_en_cnt++;
            if (if_a.en && if_a.sclk && !prev) begin
                m_bits = {m_bits[7:0], if_a.sdata};
                m_nrise++;
            end
            prev = if_a.sclk;
            if (c == 1) m_setup = {if_a.en, if_a.sclk, if_a.sdata, if_a.busy, if_a.req_ready};
            if (c == 19 * D_A) m_hold = {if_a.en, if_a.sdata};
            if (if_a.done && m_done_at == 0) begin
                m_done_at  = c;
                m_done_out = {if_a.en, if_a.sclk, if_a.sdata, if_a.req_ready, if_a.busy};
                m_sr       = sr_a;
            end
            if (m_done_at != 0 && c == m_done_at + 1) begin
                m_idle_busy = if_a.busy;
                m_rb_after  = if_a.rb_err;
            end
            if (c == pulse_at) begin
                if_a.req_valid = 1'b1;
                if_a.req_word  = 9'h0F0;
            end else if (pulse_at != 0 && c == pulse_at + 1) begin
                if_a.req_valid = 1'b0;
            end
        end
    endtask

    task automatic test_reset;
        if_a.req_valid = 1'b0; if_a.req_word = 9'd0;
        if_b.req_valid = 1'b0; if_b.req_word = 9'd0;
        rst_a = 1'b0; rst_b = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({if_a.sclk, if_a.sdata, if_a.en, if_a.busy, if_a.done, if_a.rb_err, if_a.req_ready} !== 7'b0000001) begin
            n_fail++;
            $display("FAIL reset_a: got %b expected 0000001", {if_a.sclk, if_a.sdata, if_a.en, if_a.busy, if_a.done, if_a.rb_err, if_a.req_ready});
        end
        n_tests++;
        if ({if_b.sclk, if_b.sdata, if_b.en, if_b.busy, if_b.done, if_b.rb_err, if_b.req_ready} !== 7'b0000001) begin
            n_fail++;
            $display("FAIL reset_b: got %b expected 0000001", {if_b.sclk, if_b.sdata, if_b.en, if_b.busy, if_b.done, if_b.rb_err, if_b.req_ready});
        end
        rst_a = 1'b1; rst_b = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({if_a.busy, if_a.en, if_a.req_ready} !== 3'b001) begin
            n_fail++;
            $display("FAIL reset_release_idle: got %b expected 001", {if_a.busy, if_a.en, if_a.req_ready});
        end
    endtask

    task automatic test_single;
        logic [8:0] w;
        w = 9'h1A5;
        drive_a(w, 0);
        n_tests++;
        if (m_bits !== 9'b110100101) begin n_fail++; $display("FAIL single_bits: got %b expected 110100101", m_bits); end
        n_tests++;
        if (m_nrise !== 9) begin n_fail++; $display("FAIL single_rises: got %0d expected 9", m_nrise); end
        n_tests++;
        if (m_en_cnt !== 19 * D_A) begin n_fail++; $display("FAIL single_en_cycles: got %0d expected %0d", m_en_cnt, 19 * D_A); end
        n_tests++;
        if (m_done_at !== 19 * D_A + 1) begin n_fail++; $display("FAIL single_done_at: got %0d expected %0d", m_done_at, 19 * D_A + 1); end
        n_tests++;
        if (m_setup !== {1'b1, 1'b0, w[8], 1'b1, 1'b0}) begin n_fail++; $display("FAIL single_setup: got %b expected %b", m_setup, {1'b1, 1'b0, w[8], 1'b1, 1'b0}); end
        n_tests++;
        if (m_hold !== 2'b10) begin n_fail++; $display("FAIL single_hold: got %b expected 10", m_hold); end
        n_tests++;
        if (m_done_out !== 5'b00011) begin n_fail++; $display("FAIL single_done_outputs: got %b expected 00011", m_done_out); end
        n_tests++;
        if (m_idle_busy !== 1'b0) begin n_fail++; $display("FAIL single_idle_after: got %b expected 0", m_idle_busy); end
        n_tests++;
        if (m_sr !== w) begin n_fail++; $display("FAIL single_shiftreg: got %h expected %h", m_sr, w); end
    endtask

    task automatic test_random;
        logic [8:0] w;
        for (int i = 0; i < 6; i++) begin
            w = 9'($urandom);
            drive_a(w, 0);
            n_tests++;
            if (m_bits !== w) begin n_fail++; $display("FAIL random_bits[%0d]: got %h expected %h", i, m_bits, w); end
            n_tests++;
            if (m_sr !== w || m_en_cnt !== 19 * D_A || m_done_at !== 19 * D_A + 1) begin
                n_fail++;
                $display("FAIL random_xfer[%0d]: sr %h en %0d done %0d expected %h %0d %0d", i, m_sr, m_en_cnt, m_done_at, w, 19 * D_A, 19 * D_A + 1);
            end
            n_tests++;
            if (if_a.rb_err !== 1'b0) begin n_fail++; $display("FAIL random_rb_err[%0d]: got %b expected 0", i, if_a.rb_err); end
        end
    endtask

    task automatic test_busy_reject;
        drive_a(9'h12B, 10);
        n_tests++;
        if (m_sr !== 9'h12B || m_bits !== 9'h12B) begin n_fail++; $display("FAIL busy_reject_word: sr %h bits %h expected 12b", m_sr, m_bits); end
        n_tests++;
        if (m_en_cnt !== 19 * D_A || m_done_at !== 19 * D_A + 1) begin
            n_fail++;
            $display("FAIL busy_reject_timing: en %0d done %0d expected %0d %0d", m_en_cnt, m_done_at, 19 * D_A, 19 * D_A + 1);
        end
    endtask

    task automatic test_back_to_back;
        int         d1, d2;
        logic [8:0] sr1, sr2;
        logic       en_after, rdy_done;
        d1 = 0; d2 = 0; sr1 = 9'h1AA; sr2 = 9'h1AA; en_after = 1'b0; rdy_done = 1'b0;
        @(negedge clk);
        if_a.req_valid = 1'b1;
        if_a.req_word  = 9'h000;
        @(posedge clk);
        #1;
        if_a.req_word = 9'h1FF;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (if_a.done) begin
                if (d1 == 0) begin d1 = c; sr1 = sr_a; rdy_done = if_a.req_ready; end
                else if (d2 == 0) begin d2 = c; sr2 = sr_a; end
            end
            if (d1 != 0 && c == d1 + 1) begin
                en_after = if_a.en;
                if_a.req_valid = 1'b0;
            end
            if (d2 != 0) break;
        end
        if_a.req_valid = 1'b0;
        n_tests++;
        if (d1 !== 19 * D_A + 1) begin n_fail++; $display("FAIL b2b_first_done: got %0d expected %0d", d1, 19 * D_A + 1); end
        n_tests++;
        if (d2 - d1 !== 19 * D_A + 1) begin n_fail++; $display("FAIL b2b_done_spacing: got %0d expected %0d", d2 - d1, 19 * D_A + 1); end
        n_tests++;
        if (en_after !== 1'b1 || rdy_done !== 1'b1) begin n_fail++; $display("FAIL b2b_no_gap: en %b ready %b expected 1 1", en_after, rdy_done); end
        n_tests++;
        if (sr1 !== 9'h000 || sr2 !== 9'h1FF) begin n_fail++; $display("FAIL b2b_words: got %h %h expected 000 1ff", sr1, sr2); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int   nr;
        logic prev, seen_done;
        nr = 0; prev = 1'b0; seen_done = 1'b0;
        @(negedge clk);
        if_a.req_valid = 1'b1;
        if_a.req_word  = 9'h1FF;
        @(posedge clk);
        #1;
        if_a.req_valid = 1'b0;
        for (int c = 1; c <= 40 && nr < 4; c++) begin
            @(negedge clk);
            if (if_a.done) seen_done = 1'b1;
            if (if_a.en && if_a.sclk && !prev) nr++;
            prev = if_a.sclk;
        end
        n_tests++;
        if (nr !== 4) begin n_fail++; $display("FAIL rstmid_reach_4_rises: got %0d expected 4", nr); end
        #1 rst_a = 1'b0;
        #1;
        n_tests++;
        if ({if_a.sclk, if_a.en, if_a.sdata, if_a.busy, if_a.req_ready} !== 5'b00001) begin
            n_fail++;
            $display("FAIL rstmid_async_clear: got %b expected 00001", {if_a.sclk, if_a.en, if_a.sdata, if_a.busy, if_a.req_ready});
        end
        repeat (3) begin @(negedge clk); if (if_a.done) seen_done = 1'b1; end
        rst_a = 1'b1;
        repeat (45) begin @(negedge clk); if (if_a.done || if_a.en) seen_done = 1'b1; end
        n_tests++;
        if (seen_done !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_done: got %b expected 0", seen_done); end
    endtask

    task automatic test_readback;
        logic before_clear;
        int   g;
        rb_force_a = 1'b1;
        drive_a(9'h055, 0);
        rb_force_a = 1'b0;
`ifdef DSM_CFG_READBACK_EN
        n_tests++;
        if (m_rb_after !== 1'b1 || if_a.rb_err !== 1'b1) begin n_fail++; $display("FAIL readback_set: got %b %b expected 1 1", m_rb_after, if_a.rb_err); end
        @(negedge clk);
        if_a.req_valid = 1'b1;
        if_a.req_word  = 9'($urandom);
        before_clear = if_a.rb_err;
        @(posedge clk);
        #1;
        if_a.req_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (before_clear !== 1'b1 || if_a.rb_err !== 1'b0) begin n_fail++; $display("FAIL readback_clear: got %b %b expected 1 0", before_clear, if_a.rb_err); end
        g = 0;
        while (if_a.busy && g < 100) begin @(negedge clk); g++; end
`else
        before_clear = 1'b0;
        g = 0;
        n_tests++;
        if (m_rb_after !== 1'b0 || if_a.rb_err !== 1'b0 || before_clear !== 1'b0 || g != 0) begin
            n_fail++;
            $display("FAIL readback_disabled: got %b %b expected 0 0", m_rb_after, if_a.rb_err);
        end
`endif
    endtask

    task automatic test_clkdiv1;
        logic [8:0] w, bits;
        int         en_cnt, nrise, done_at, ones, last_rise, bad_period;
        logic       prev;
        for (int i = 0; i < 3; i++) begin
            w = (i == 0) ? 9'h100 : 9'($urandom);
            en_cnt = 0; nrise = 0; done_at = 0; ones = 0; last_rise = 0; bad_period = 0; bits = 9'd0; prev = 1'b0;
            @(negedge clk);
            if_b.req_valid = 1'b1;
            if_b.req_word  = w;
            @(posedge clk);
            #1;
            if_b.req_valid = 1'b0;
            for (int c = 1; c <= 25; c++) begin
                @(negedge clk);
                if (if_b.en) en_cnt++;
                if (if_b.en && if_b.sdata) ones++;
                if (if_b.en && if_b.sclk && !prev) begin
                    if (nrise != 0 && c - last_rise != 2) bad_period++;
                    last_rise = c;
                    bits = {bits[7:0], if_b.sdata};
                    nrise++;
                end
                prev = if_b.sclk;
                if (if_b.done && done_at == 0) done_at = c;
            end
            n_tests++;
            if (bits !== w || nrise !== 9) begin n_fail++; $display("FAIL div1_bits[%0d]: got %h/%0d expected %h/9", i, bits, nrise, w); end
            n_tests++;
            if (en_cnt !== 19 || done_at !== 20) begin n_fail++; $display("FAIL div1_timing[%0d]: en %0d done %0d expected 19 20", i, en_cnt, done_at); end
            n_tests++;
            if (bad_period !== 0) begin n_fail++; $display("FAIL div1_period[%0d]: got %0d bad periods expected 0", i, bad_period); end
            if (i == 0) begin
                n_tests++;
                if (ones !== 2) begin n_fail++; $display("FAIL div1_msb_only: got %0d sdata-high cycles expected 2", ones); end
            end
        end
    endtask

    initial begin
        if_a.req_valid = 1'b0; if_a.req_word = 9'd0;
        if_b.req_valid = 1'b0; if_b.req_word = 9'd0;
        test_reset;
        test_single;
        test_random;
        test_busy_reject;
        test_back_to_back;
        test_reset_mid;
        test_readback;
        test_clkdiv1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/dsm_cfg_ctrl.md
DSM_CFG_CTRL -- requirements
Module: dsm_cfg_ctrl

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 2, giving the sclk half-period in clk_dsm cycles; the legal range is 1..255.
REQ-002 The block SHALL have input clk_dsm, 1 bit, the single clock; all logic is rising-edge clocked.
REQ-003 The block SHALL have input rst_n, 1 bit, the reset, which is asynchronous and active-low.
REQ-004 The block SHALL have input req_valid, 1 bit, indicating that a new word is offered.
REQ-005 The block SHALL have input req_word, 9 bits, the word to program into the serial shift register.
REQ-006 The block SHALL have output req_ready, 1 bit, indicating that the controller is idle and can accept a word.
REQ-007 The block SHALL have output sclk, 1 bit, the serial clock to the shift register.
REQ-008 The block SHALL have output sdata, 1 bit, the serial data, sent MSB first.
REQ-009 The block SHALL have output en, 1 bit, the shift-register load enable.
REQ-010 The block SHALL have output busy, 1 bit, high whenever the controller is not in IDLE.
REQ-011 The block SHALL have output done, 1 bit, a 1-cycle pulse marking the end of a transfer.
REQ-012 The block SHALL have input rb_word, 9 bits, the parallel readback of the shift register.
REQ-013 The block SHALL have output rb_err, 1 bit, a sticky readback-mismatch flag.

Function
REQ-014 The FSM SHALL have the states IDLE, SETUP, SHIFT_HI, SHIFT_LO and DONE.
REQ-015 A word SHALL be accepted only on a clk_dsm edge where req_valid=1 and req_ready=1; req_word is then captured into a 9-bit shadow register and the bit counter is set to 8.
REQ-016 req_ready SHALL equal 1 only in the IDLE and DONE states.
REQ-017 req_valid SHALL be ignored while req_ready=0, so no word is lost or queued.
REQ-018 In SETUP (CLK_DIV cycles), outputs SHALL be en=1, sclk=0, sdata=shadow[8].
REQ-019 In SHIFT_HI (CLK_DIV cycles), sclk=1 and sdata SHALL be held stable.
REQ-020 In SHIFT_LO (CLK_DIV cycles), sclk=0 and sdata SHALL present the next lower bit.
REQ-021 After the SHIFT_LO that follows bit 0, sdata SHALL be 0 and en SHALL stay 1 as a hold phase.
REQ-022 The FSM SHALL step SHIFT_HI->SHIFT_LO for each bit, and SHIFT_LO->SHIFT_HI while the bit counter is greater than 0; otherwise it moves to DONE.
REQ-023 en SHALL be high for exactly 19*CLK_DIV cycles per transfer, and sclk SHALL produce exactly 9 rising edges while en=1.
REQ-024 DONE SHALL last 1 cycle, with en=0, sclk=0, sdata=0 and done=1; the done cycle is edge 19*CLK_DIV+1 after acceptance.
REQ-025 A handshake in DONE SHALL start SETUP on the next cycle (back-to-back operation with no idle gap); otherwise the FSM returns to IDLE.
REQ-026 The half-period counter SHALL be 8 bits wide; it reloads to CLK_DIV-1 at each phase entry and the phase ends when it reaches 0.
REQ-027 With CLK_DIV=1, sclk SHALL toggle every cycle.
REQ-028 sclk, sdata and en SHALL be driven directly from flops, with no glitches.

Reset
REQ-029 On rst_n=0, the state SHALL be IDLE and the shadow register, bit counter and divider counter SHALL be 0, immediately and asynchronously.
REQ-030 During reset, outputs SHALL be sclk=0, sdata=0, en=0, busy=0, done=0, rb_err=0 and req_ready=1.
REQ-031 A reset in the middle of a transfer SHALL abort it with no done pulse; the partially shifted downstream word is not repaired, and the user must reprogram.
REQ-032 Reset deassertion SHALL take effect on the next clk_dsm edge.

Configuration
REQ-033 The macro DSM_CFG_READBACK_EN SHALL select readback checking.
REQ-034 When DSM_CFG_READBACK_EN is defined, in the DONE cycle rb_word is compared with the shadow; a mismatch sets rb_err, which stays high until the next accepted request clears it.
REQ-035 When DSM_CFG_READBACK_EN is not defined, rb_word SHALL be unused and rb_err tied to 0; all other behaviour SHALL be identical and the port list SHALL be unchanged.

Verification
REQ-036 The bench SHALL check a single transfer: CLK_DIV=2, word 9'h1A5 -> sdata sampled at sclk rising edges = 1,1,0,1,0,0,1,0,1; en high for 38 cycles; done at edge 39.
REQ-037 The bench SHALL check back-to-back transfers: req_valid held with 9'h000 then 9'h1FF -> the second SETUP starts the cycle after DONE, and 2 done pulses occur 39 cycles apart.
REQ-038 The bench SHALL check busy rejection: req_valid pulsed with 9'h0F0 mid-transfer -> ignored, and the shift register holds the first word.
REQ-039 The bench SHALL check reset mid-transfer: rst_n low after 4 sclk rising edges -> sclk, en and sdata go to 0 at once, with no done pulse.
REQ-040 The bench SHALL check readback (DSM_CFG_READBACK_EN defined): rb_word forced to 9'h000 for word 9'h055 -> rb_err=1 after DONE, cleared by the next handshake; with the macro undefined, rb_err stays 0.
REQ-041 The bench SHALL check CLK_DIV=1 with word 9'h100 -> sclk period of 2 cycles, en high for 19 cycles, and sdata=1 only for the first bit.
